// File: rtl/mem_pwm_pkg.sv
// Register map and shared helpers for the memory-mapped PWM block.
package mem_pwm_pkg;

  // Byte offsets of the registers (only address bits [7:2] are decoded)
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_PRESC  = 8'h04;
  localparam logic [7:0] REG_PERIOD = 8'h08;
  localparam logic [7:0] REG_COUNT  = 8'h0C;
  localparam logic [7:0] REG_STATUS = 8'h10;
  localparam logic [7:0] REG_DUTY0  = 8'h20;

  // CTRL / STATUS bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQEN  = 1;
  localparam int CTRL_OE_LSB = 8;
  localparam int STATUS_WRAP = 0;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Merge a bus write into an existing register word, one byte lane per strobe bit
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_pwm_compare.sv
// One PWM channel: staging/active duty pair and the registered compare output.
module pwm_compare #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             reload,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] duty_stg,
  output logic             pwm_do
);

  logic [WIDTH-1:0] duty_stg_q, duty_stg_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic             do_q, do_d;

  // Staging takes bus writes; active copy only moves on reload so a period never sees a torn duty
  always_comb begin
    duty_stg_d = wr_en  ? wr_data    : duty_stg_q;
    duty_act_d = reload ? duty_stg_q : duty_act_q;
    do_d       = en & (cnt < duty_act_q);
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      duty_stg_q <= '0;
      duty_act_q <= '0;
      do_q       <= 1'b0;
    end else begin
      duty_stg_q <= duty_stg_d;
      duty_act_q <= duty_act_d;
      do_q       <= do_d;
    end
  end

  assign duty_stg = duty_stg_q;
  assign pwm_do   = do_q;

endmodule

// File: rtl/mem_pwm.sv
// Memory-mapped PWM generator: iomem bus slave, shared prescaler/period counter, NCH channels.
module mem_pwm
  import mem_pwm_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           mem_valid,
  output logic           mem_ready,
  input  logic [31:0]    mem_addr,
  output logic [31:0]    mem_rdata,
  input  logic [31:0]    mem_wdata,
  input  logic [3:0]     mem_wstrb,
  output logic [NCH-1:0] pwm_oe,
  output logic [NCH-1:0] pwm_do,
  output logic           irq
);

  // Only EN, IRQEN and the OE bits of implemented channels are stored; the rest read 0
  localparam logic [31:0] CTRL_MASK = {16'h0, 8'((1 << NCH) - 1), 6'h0, 2'b11};

  bus_state_e       state_q, state_d;
  logic [31:0]      ctrl_q, ctrl_d;
  logic [15:0]      presc_q, presc_d;
  logic [WIDTH-1:0] period_stg_q, period_stg_d;
  logic [WIDTH-1:0] period_act_q, period_act_d;
  logic [15:0]      pcnt_q, pcnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  logic [7:0]       off;
  logic             wr_go;
  logic             en;
  logic             tick;
  logic             wrap_evt;
  logic             reload;
  logic [31:0]      rd_data;
  logic [WIDTH-1:0] duty_stg [NCH];
  logic             unused_addr;

  assign off         = {mem_addr[7:2], 2'b00};
  assign unused_addr = ^{mem_addr[31:8], mem_addr[1:0]};
  assign wr_go       = mem_ready & mem_valid & (|mem_wstrb);
  assign en          = ctrl_q[CTRL_EN];

  // Bus FSM state register; async reset drops mem_ready immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= BUS_IDLE;
    else       state_q <= state_d;
  end

  // Bus FSM next state: one ACK cycle per request, always back through IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (mem_valid) state_d = BUS_ACK;
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  // Bus FSM outputs: ready pulse and read data gated by it
  always_comb begin
    mem_ready = (state_q == BUS_ACK);
    mem_rdata = mem_ready ? rd_data : 32'h0;
  end

  // Read mux; unmapped offsets and absent channels return 0
  always_comb begin
    rd_data = 32'h0;
    case (off)
      REG_CTRL:   rd_data = ctrl_q;
      REG_PRESC:  rd_data = 32'(presc_q);
      REG_PERIOD: rd_data = 32'(period_stg_q);
      REG_COUNT:  rd_data = 32'(cnt_q);
      REG_STATUS: rd_data = 32'(wrap_q);
      default: begin
        for (int n = 0; n < NCH; n++) begin
          if (off == REG_DUTY0 + 8'(4 * n)) rd_data = 32'(duty_stg[n]);
        end
      end
    endcase
  end

  // Prescaler tick and period wrap; reload follows staging continuously while disabled
  always_comb begin
    tick     = en & (pcnt_q == presc_q);
    wrap_evt = tick & (cnt_q == period_act_q);
    reload   = ~en | wrap_evt;
  end

  // Register writes, counters and WRAP flag next-state
  always_comb begin
    ctrl_d       = ctrl_q;
    presc_d      = presc_q;
    period_stg_d = period_stg_q;
    if (wr_go) begin
      case (off)
        REG_CTRL:   ctrl_d       = apply_wstrb(ctrl_q, mem_wdata, mem_wstrb) & CTRL_MASK;
        REG_PRESC:  presc_d      = 16'(apply_wstrb(32'(presc_q), mem_wdata, mem_wstrb));
        REG_PERIOD: period_stg_d = WIDTH'(apply_wstrb(32'(period_stg_q), mem_wdata, mem_wstrb));
        default:    ;
      endcase
    end

    period_act_d = reload ? period_stg_q : period_act_q;

    if (!en) begin
      pcnt_d = 16'h0;
      cnt_d  = '0;
    end else if (tick) begin
      pcnt_d = 16'h0;
      cnt_d  = wrap_evt ? '0 : cnt_q + 1'b1;
    end else begin
      pcnt_d = pcnt_q + 16'd1;
      cnt_d  = cnt_q;
    end

    // Hardware set beats a simultaneous write-1-to-clear
    if (wrap_evt)
      wrap_d = 1'b1;
    else if (wr_go && (off == REG_STATUS) && mem_wstrb[0] && mem_wdata[STATUS_WRAP])
      wrap_d = 1'b0;
    else
      wrap_d = wrap_q;
  end

  // Control/status/counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q       <= 32'h0;
      presc_q      <= 16'h0;
      period_stg_q <= '0;
      period_act_q <= '0;
      pcnt_q       <= 16'h0;
      cnt_q        <= '0;
      wrap_q       <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      presc_q      <= presc_d;
      period_stg_q <= period_stg_d;
      period_act_q <= period_act_d;
      pcnt_q       <= pcnt_d;
      cnt_q        <= cnt_d;
      wrap_q       <= wrap_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic             dsel;
    logic [WIDTH-1:0] dwr;
    assign dsel = wr_go & (off == REG_DUTY0 + 8'(4 * g));
    assign dwr  = WIDTH'(apply_wstrb(32'(duty_stg[g]), mem_wdata, mem_wstrb));

    pwm_compare #(.WIDTH(WIDTH)) u_cmp (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (dsel),
      .wr_data  (dwr),
      .reload   (reload),
      .en       (en),
      .cnt      (cnt_q),
      .duty_stg (duty_stg[g]),
      .pwm_do   (pwm_do[g])
    );
  end

  assign pwm_oe = ctrl_q[CTRL_OE_LSB +: NCH];
  assign irq    = wrap_q & ctrl_q[CTRL_IRQEN];

endmodule
